axis_word_packer: RTL
=====================

AXIS_WORD_PACKER -- requirements
Module: axis_word_packer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning the width of one data word in bits.
REQ-002 The block SHALL have parameter BUS_W, default 32, meaning the master data bus width in bits.
REQ-003 The block SHALL have derived parameter WORDS_PER_BEAT, default BUS_W/WORD_W, meaning word lanes per beat (N).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port s_valid, input, 1 bit: slave word valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit: slave word ready.
REQ-008 The block SHALL have port s_data, input, WORD_W bits: slave word.
REQ-009 The block SHALL have port s_last, input, 1 bit: final word of the packet.
REQ-010 The block SHALL have port m_valid, output, 1 bit: master beat valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit: master beat ready.
REQ-012 The block SHALL have port m_data, output, [N-1:0][WORD_W-1:0]: beat, lane 0 = first word.
REQ-013 The block SHALL have port m_keep, output, N bits: lane-valid mask.
REQ-014 The block SHALL have port m_last, output, 1 bit: final beat of the packet.

Function
REQ-015 A word SHALL be accepted when s_valid&s_ready at a rising edge; a beat SHALL transfer when m_valid&m_ready.
REQ-016 Accepted words SHALL fill an accumulation buffer in lanes 0,1,..N-1 in arrival order, tracked by a lane counter 0..N-1.
REQ-017 The buffer SHALL close when lane N-1 is written or a word with s_last=1 is accepted; the counter SHALL then wrap to 0.
REQ-018 On close, the beat SHALL move to the output register on the same edge if that register is empty or being drained that cycle; otherwise the buffer SHALL hold it as pending.
REQ-019 s_ready SHALL be 0 exactly while a pending beat exists; otherwise 1.
REQ-020 m_valid SHALL rise the cycle after the closing word is accepted (latency 1); sustained throughput SHALL be one word per cycle with m_ready=1.
REQ-021 m_keep SHALL be contiguous low ones equal to the number of words in the beat; lanes with keep=0 SHALL carry zero data.
REQ-022 m_last SHALL be 1 only on the beat containing the s_last word; a packet whose length is a multiple of N SHALL end with m_keep all ones and m_last=1, with no empty beat.
REQ-023 m_valid, m_data, m_keep and m_last SHALL be held stable while m_valid=1 and m_ready=0.
REQ-024 A pending beat SHALL move to the output register on the edge the output beat transfers; s_ready SHALL return to 1 on that edge.
REQ-025 With N=1, each word SHALL produce one beat with m_keep=1'b1 and m_last=s_last.
REQ-026 BUS_W not divisible by WORD_W SHALL cause an elaboration-time fatal error.

Reset
REQ-027 On rst=1 at a rising edge, m_valid, m_data, m_keep, m_last, the lane counter and the pending flag SHALL clear to 0, and s_ready SHALL read 1 the next cycle.
REQ-028 Reset mid-packet SHALL discard all partial and pending words; the next accepted word SHALL start a new packet in lane 0.
REQ-029 While rst=1, s_ready SHALL be 0.

Configuration
REQ-030 With macro AXIS_WORD_PACKER_PKT_CNT_EN defined, the block SHALL add an output pkt_count, 32 bits: it increments on each m_valid&m_ready&m_last, wraps at 2^32, and clears on rst.
REQ-031 Without AXIS_WORD_PACKER_PKT_CNT_EN, the port and the counter SHALL be absent.

Structure
REQ-032 Package axis_vip_pkg SHALL hold default WORD_W/BUS_W constants and a typedef for the keep-mask/lane-count helper function.
REQ-033 The output register with its hold-on-stall logic SHALL be a sub-module, axis_beat_reg.

Verification
REQ-034 Scenario 1: WORD_W=8, BUS_W=32, m_ready=1; words 1..8, last on 8 -> two beats, keep=4'hF, m_last=0 then 1, data {4,3,2,1},{8,7,6,5}.
REQ-035 Scenario 2: words 1..5, last on 5 -> beat 2 has keep=4'h1, data lane0=5, lanes1-3=0, m_last=1.
REQ-036 Scenario 3: m_ready=0 for 20 cycles while feeding 12 words -> s_ready drops after word 8; output beat is stable; 3 beats delivered intact after release, in order.
REQ-037 Scenario 4: rst pulse after 2 words of a packet, then words 9,10 with last on 10 -> single beat keep=4'h3, data {0,0,10,9}, m_last=1.
REQ-038 Scenario 5: random s_valid/m_ready (20% ready, the same probability the sink uses), 1000 packets of length 1..37 -> reassembled word streams match the input; no keep holes.
REQ-039 Scenario 6: with AXIS_WORD_PACKER_PKT_CNT_EN, 3 packets sent -> pkt_count=3; after rst -> pkt_count=0.

Source files
------------

// File: rtl/axis_word_packer_pkg.sv
// Shared defaults and lane/keep helper for the AXI-Stream word packer.
// The keep mask is built one lane at a time so any lane count works without width casts.
package axis_vip_pkg;

  localparam int WORD_W_DEFAULT = 8;
  localparam int BUS_W_DEFAULT  = 32;

  typedef logic [31:0] lane_cnt_t;

  // A lane is kept when its index is below the number of words in the beat.
  function automatic logic lane_kept(input lane_cnt_t lane, input lane_cnt_t count);
    return lane < count;
  endfunction

endpackage

// File: rtl/axis_word_packer_if.sv
// Word-in / beat-out stream bundle for axis_word_packer.
// The slave modport is the packer's view; master is the driving environment.
interface axis_word_packer_if
  import axis_vip_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT,
  parameter int N      = BUS_W_DEFAULT / WORD_W_DEFAULT
);

  logic                       s_valid;
  logic                       s_ready;
  logic [WORD_W-1:0]          s_data;
  logic                       s_last;
  logic                       m_valid;
  logic                       m_ready;
  logic [N-1:0][WORD_W-1:0]   m_data;
  logic [N-1:0]               m_keep;
  logic                       m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

endinterface

// File: rtl/axis_word_packer_beat_reg.sv
// Output beat register: loads a new beat when empty or draining, holds steady on stall.
module axis_beat_reg
  import axis_vip_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT,
  parameter int N      = BUS_W_DEFAULT / WORD_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic [N-1:0][WORD_W-1:0] load_data_i,
  input  logic [N-1:0]             load_keep_i,
  input  logic                     load_last_i,
  input  logic                     ready_i,
  output logic                     can_load_o,
  output logic                     valid_o,
  output logic [N-1:0][WORD_W-1:0] data_o,
  output logic [N-1:0]             keep_o,
  output logic                     last_o
);

  logic                     valid_q, valid_d;
  logic [N-1:0][WORD_W-1:0] data_q, data_d;
  logic [N-1:0]             keep_q, keep_d;
  logic                     last_q, last_d;

  assign can_load_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (can_load_o) begin
      valid_d = load_i;
      if (load_i) begin
        data_d = load_data_i;
        keep_d = load_keep_i;
        last_d = load_last_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/axis_word_packer.sv
// Packs WORD_W-bit stream words into BUS_W-bit beats with keep/last framing.
// Optional packet counter output pkt_count is enabled by AXIS_WORD_PACKER_PKT_CNT_EN.
module axis_word_packer
  import axis_vip_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT,
  parameter int BUS_W  = BUS_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  axis_word_packer_if.slave   bus
`ifdef AXIS_WORD_PACKER_PKT_CNT_EN
  ,
  output logic [31:0]         pkt_count
`endif
);

  localparam int WORDS_PER_BEAT = BUS_W / WORD_W;
  localparam int N              = WORDS_PER_BEAT;
  localparam int CNT_W          = (N > 1) ? $clog2(N) : 1;

  if ((BUS_W % WORD_W) != 0) begin : g_width_check
    $fatal(1, "axis_word_packer: BUS_W must be a multiple of WORD_W");
  end

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N-1:0][WORD_W-1:0] buf_q, buf_d;
  logic                     pend_q, pend_d;
  logic [N-1:0]             pend_keep_q, pend_keep_d;
  logic                     pend_last_q, pend_last_d;

  logic [N-1:0][WORD_W-1:0] close_data;
  logic [N-1:0]             close_keep;
  logic                     accept;
  logic                     close;
  logic                     can_load;
  logic                     load;
  logic [N-1:0][WORD_W-1:0] load_data;
  logic [N-1:0]             load_keep;
  logic                     load_last;

  assign bus.s_ready = !rst && !pend_q;
  assign accept      = bus.s_valid && bus.s_ready;
  assign close       = accept && (bus.s_last || (cnt_q == CNT_W'(N - 1)));

  // Lanes above the counter are always zero in buf_q, so the closing beat needs no masking.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_lane
    assign close_data[gi] = (lane_cnt_t'(gi) == lane_cnt_t'(cnt_q)) ? bus.s_data : buf_q[gi];
    assign close_keep[gi] = lane_kept(lane_cnt_t'(gi), lane_cnt_t'(cnt_q) + 1);
  end

  always_comb begin
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    pend_d      = pend_q;
    pend_keep_d = pend_keep_q;
    pend_last_d = pend_last_q;
    load        = 1'b0;
    load_data   = close_data;
    load_keep   = close_keep;
    load_last   = bus.s_last;
    if (pend_q) begin
      // No words are accepted while pending, so the buffer only waits to drain.
      load      = 1'b1;
      load_data = buf_q;
      load_keep = pend_keep_q;
      load_last = pend_last_q;
      if (can_load) begin
        buf_d  = '0;
        pend_d = 1'b0;
      end
    end else if (close) begin
      load  = 1'b1;
      cnt_d = '0;
      if (can_load) begin
        buf_d = '0;
      end else begin
        buf_d       = close_data;
        pend_d      = 1'b1;
        pend_keep_d = close_keep;
        pend_last_d = bus.s_last;
      end
    end else if (accept) begin
      buf_d[cnt_q] = bus.s_data;
      cnt_d        = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      pend_q      <= 1'b0;
      pend_keep_q <= '0;
      pend_last_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      pend_q      <= pend_d;
      pend_keep_q <= pend_keep_d;
      pend_last_q <= pend_last_d;
    end
  end

  axis_beat_reg #(
    .WORD_W (WORD_W),
    .N      (N)
  ) u_beat_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i (load_data),
    .load_keep_i (load_keep),
    .load_last_i (load_last),
    .ready_i     (bus.m_ready),
    .can_load_o  (can_load),
    .valid_o     (bus.m_valid),
    .data_o      (bus.m_data),
    .keep_o      (bus.m_keep),
    .last_o      (bus.m_last)
  );

`ifdef AXIS_WORD_PACKER_PKT_CNT_EN
  logic [31:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (bus.m_valid && bus.m_ready && bus.m_last) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule
